hazard_stall_ctrl: RTL and testbench

ID-stage hazard detection and stall/flush controller for the 5-stage pipeline. It is the stalling counterpart of the forwarding unit. Forwarding resolves RAW hazards by bypassing. This block resolves the hazards that bypassing cannot: load-use, all RAW hazards when forwarding is disabled, and taken-branch flushes. It does this by freezing PC and IF/ID, injecting bubbles into ID/EX, and flushing wrong-path instructions. It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl_if.sv | 34 +++
 rtl/hazard_stall_ctrl.sv | 94 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of the ID-stage hazard controller's pipeline-side signals.
// The pipeline drives the hazard inputs (master), and the controller returns the stall and flush controls (slave).
interface hazard_stall_ctrl_if;
    logic        forward_en;
    logic [4:0]  regS_addr;
    logic [4:0]  regT_addr;
    logic        use_regS;
    logic        use_regT;
    logic        reg_wr_en_ex;
    logic [4:0]  reg_wr_addr_ex;
    logic        mem_rd_ex;
    logic        reg_wr_en_mem;
    logic [4:0]  reg_wr_addr_mem;
    logic        branch_taken_ex;
    logic        pc_wr_en;
    logic        ifid_wr_en;
    logic        idex_bubble;
    logic        ifid_flush;
    logic [15:0] stall_cycles;

    modport master (
        output forward_en, regS_addr, regT_addr, use_regS, use_regT,
               reg_wr_en_ex, reg_wr_addr_ex, mem_rd_ex,
               reg_wr_en_mem, reg_wr_addr_mem, branch_taken_ex,
        input  pc_wr_en, ifid_wr_en, idex_bubble, ifid_flush, stall_cycles
    );

    modport slave (
        input  forward_en, regS_addr, regT_addr, use_regS, use_regT,
               reg_wr_en_ex, reg_wr_addr_ex, mem_rd_ex,
               reg_wr_en_mem, reg_wr_addr_mem, branch_taken_ex,
        output pc_wr_en, ifid_wr_en, idex_bubble, ifid_flush, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the ID stage. It freezes PC and IF/ID and bubbles ID/EX for
// hazards that bypassing cannot cover, flushes on a taken branch, and counts stalled cycles.
module hazard_stall_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    hazard_stall_ctrl_if.slave   bus
);

    typedef enum logic {RUN, STALL} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [15:0] stall_cnt;

    logic        hz_ex;
    logic        hz_mem;
    logic [1:0]  need;
    logic        stall;
    logic        flush;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    always_comb begin
        hz_ex  = bus.reg_wr_en_ex && (bus.reg_wr_addr_ex != 5'd0) &&
                 ((bus.use_regS && (bus.reg_wr_addr_ex == bus.regS_addr)) ||
                  (bus.use_regT && (bus.reg_wr_addr_ex == bus.regT_addr)));
        hz_mem = bus.reg_wr_en_mem && (bus.reg_wr_addr_mem != 5'd0) &&
                 ((bus.use_regS && (bus.reg_wr_addr_mem == bus.regS_addr)) ||
                  (bus.use_regT && (bus.reg_wr_addr_mem == bus.regT_addr)));
    end

    // WB is write-through to the register file, so only EX and MEM producers need cycles.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        need = 2'd0;
        if (bus.forward_en) begin
            if (hz_ex && bus.mem_rd_ex)
                need = 2'd1;
        end else if (hz_ex) begin
            need = 2'd2;
        end else if (hz_mem) begin
            need = 2'd1;
        end
    end

    // A taken branch wins over any stall. In STALL the hazard inputs are ignored.
    always_comb begin
        flush = bus.branch_taken_ex;
        stall = !flush && ((state == STALL) || (need != 2'd0));
    end

    assign bus.pc_wr_en     = !rst && !stall;
    assign bus.ifid_wr_en   = !rst && !stall;
    assign bus.idex_bubble  = rst || stall || flush;
    assign bus.ifid_flush   = rst || flush;
    assign bus.stall_cycles = stall_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values no matter how the statements are ordered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= 2'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;

            case (state)
                RUN: begin
                    if (!flush && (need != 2'd0)) begin
                        cnt <= need - 2'd1;
                        if (need > 2'd1)
                            state <= STALL;
                    end
                end
                STALL: begin
                    if (flush) begin
                        cnt   <= 2'd0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 2'd1;
                        if (cnt == 2'd1)
                            state <= RUN;
                    end
                end
                default: begin
                    cnt   <= 2'd0;
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed and random checks of hazard_stall_ctrl against a reference model
// that tracks the number of remaining stall cycles.
module tb_hazard_stall_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    // Reference model state: stall cycles still owed, and the stalled-cycle counter.
    int   remain;
    int   sc;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic bit depends(input logic en, input logic [4:0] dst);
        return en && (dst != 5'd0) &&
               ((bus.use_regS && dst == bus.regS_addr) || (bus.use_regT && dst == bus.regT_addr));
    endfunction

    // Stall cycles the instruction in ID needs.
    function automatic int model_need();
        if (bus.forward_en)
            return (depends(bus.reg_wr_en_ex, bus.reg_wr_addr_ex) && bus.mem_rd_ex) ? 1 : 0;
        if (depends(bus.reg_wr_en_ex, bus.reg_wr_addr_ex))
            return 2;
        if (depends(bus.reg_wr_en_mem, bus.reg_wr_addr_mem))
            return 1;
        return 0;
    endfunction

    task automatic clear_inputs();
        bus.regS_addr       = 5'd0;
        bus.regT_addr       = 5'd0;
        bus.use_regS        = 1'b0;
        bus.use_regT        = 1'b0;
        bus.reg_wr_en_ex    = 1'b0;
        bus.reg_wr_addr_ex  = 5'd0;
        bus.mem_rd_ex       = 1'b0;
        bus.reg_wr_en_mem   = 1'b0;
        bus.reg_wr_addr_mem = 5'd0;
        bus.branch_taken_ex = 1'b0;
    endtask

    // This task is called just after a rising edge with the inputs already applied.
    // It checks the outputs mid-cycle, then advances the model across the next edge.
    task automatic step(input bit chk);
        int  n;
        bit  e_stall;
        bit  e_flush;
        #3;
        n       = model_need();
        e_flush = bus.branch_taken_ex;
        e_stall = !e_flush && (remain > 0 || n > 0);
        if (chk) begin
            if (rst) begin
                check("rst_pc_wr_en",    16'(bus.pc_wr_en),    16'd0);
                check("rst_ifid_wr_en",  16'(bus.ifid_wr_en),  16'd0);
                check("rst_idex_bubble", 16'(bus.idex_bubble), 16'd1);
                check("rst_ifid_flush",  16'(bus.ifid_flush),  16'd1);
            end else begin
                check("pc_wr_en",    16'(bus.pc_wr_en),    16'(!e_stall));
                check("ifid_wr_en",  16'(bus.ifid_wr_en),  16'(!e_stall));
                check("idex_bubble", 16'(bus.idex_bubble), 16'(e_stall || e_flush));
                check("ifid_flush",  16'(bus.ifid_flush),  16'(e_flush));
            end
            check("stall_cycles", bus.stall_cycles, 16'(sc));
        end
        @(posedge clk);
        if (rst) begin
            remain = 0;
            sc     = 0;
        end else begin
            if (e_flush)         remain = 0;
            else if (remain > 0) remain = remain - 1;
            else if (n > 0)      remain = n - 1;
            if (e_stall && sc < 65535) sc = sc + 1;
        end
        #1;
    endtask

    task automatic reset_pulse();
        clear_inputs();
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        remain      = 0;
        sc          = 0;
        rst         = 1'b1;
        bus.forward_en = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;

        // Outputs are forced while reset is held.
        step(1'b1);
        step(1'b1);
        rst = 1'b0;

        // Load-use with forwarding: one stall cycle, then the load in MEM needs nothing.
        bus.forward_en = 1'b1;
        bus.reg_wr_en_ex = 1'b1; bus.reg_wr_addr_ex = 5'd5; bus.mem_rd_ex = 1'b1;
        bus.regS_addr = 5'd5; bus.use_regS = 1'b1;
        step(1'b1);
        bus.reg_wr_en_ex = 1'b0; bus.mem_rd_ex = 1'b0;
        bus.reg_wr_en_mem = 1'b1; bus.reg_wr_addr_mem = 5'd5;
        step(1'b1);
        check("lu_stall_cycles", bus.stall_cycles, 16'd1);

        // An ALU producer with forwarding does not stall.
        reset_pulse();
        bus.forward_en = 1'b1;
        bus.reg_wr_en_ex = 1'b1; bus.reg_wr_addr_ex = 5'd5;
        bus.regS_addr = 5'd5; bus.use_regS = 1'b1;
        step(1'b1);
        check("alu_no_stall", 16'(bus.stall_cycles), 16'd0);

        // No forwarding, EX match on rt: two stalls, MEM match ignored, then proceed.
        reset_pulse();
        bus.forward_en = 1'b0;
        bus.reg_wr_en_ex = 1'b1; bus.reg_wr_addr_ex = 5'd7;
        bus.regT_addr = 5'd7; bus.use_regT = 1'b1;
        step(1'b1);
        bus.reg_wr_en_ex = 1'b0;
        bus.reg_wr_en_mem = 1'b1; bus.reg_wr_addr_mem = 5'd7;
        step(1'b1);
        bus.reg_wr_en_mem = 1'b0;
        step(1'b1);
        check("nofwd_ex_stall_cycles", bus.stall_cycles, 16'd2);

        // Register 0 and unused rt never stall.
        reset_pulse();
        bus.forward_en = 1'b1;
        bus.reg_wr_en_ex = 1'b1; bus.reg_wr_addr_ex = 5'd0; bus.mem_rd_ex = 1'b1;
        bus.use_regS = 1'b1; bus.use_regT = 1'b1;
        step(1'b1);
        bus.forward_en = 1'b0;
        step(1'b1);
        bus.use_regS = 1'b0; bus.use_regT = 1'b0;
        bus.reg_wr_addr_ex = 5'd9; bus.regT_addr = 5'd9;
        step(1'b1);
        bus.forward_en = 1'b1;
        step(1'b1);
        check("zero_reg_stall_cycles", bus.stall_cycles, 16'd0);

        // A branch in the second stall cycle flushes instead of stalling.
        reset_pulse();
        bus.forward_en = 1'b0;
        bus.reg_wr_en_ex = 1'b1; bus.reg_wr_addr_ex = 5'd7;
        bus.regT_addr = 5'd7; bus.use_regT = 1'b1;
        step(1'b1);
        bus.reg_wr_en_ex = 1'b0;
        bus.reg_wr_en_mem = 1'b1; bus.reg_wr_addr_mem = 5'd7;
        bus.branch_taken_ex = 1'b1;
        #3;
        check("br_pc_wr_en",   16'(bus.pc_wr_en),   16'd1);
        check("br_ifid_flush", 16'(bus.ifid_flush), 16'd1);
        @(posedge clk);
        remain = 0;
        #1;
        clear_inputs();
        step(1'b1);
        check("br_stall_cycles", bus.stall_cycles, 16'd1);

        // A hazard on both rs and rt counts once.
        reset_pulse();
        bus.forward_en = 1'b0;
        bus.reg_wr_en_ex = 1'b1; bus.reg_wr_addr_ex = 5'd3;
        bus.regS_addr = 5'd3; bus.regT_addr = 5'd3;
        bus.use_regS = 1'b1; bus.use_regT = 1'b1;
        step(1'b1);
        bus.reg_wr_en_ex = 1'b0;
        step(1'b1);
        step(1'b1);
        check("dual_stall_cycles", bus.stall_cycles, 16'd2);

        // A held EX hazard drives the counter into saturation. Then reset mid-stall.
        reset_pulse();
        bus.forward_en = 1'b0;
        bus.reg_wr_en_ex = 1'b1; bus.reg_wr_addr_ex = 5'd4;
        bus.regS_addr = 5'd4; bus.use_regS = 1'b1;
        for (int i = 0; i < 65540; i++) step(1'b0);
        step(1'b1);
        check("sat_stall_cycles", bus.stall_cycles, 16'hFFFF);
        if (remain == 0) step(1'b1);
        rst = 1'b1;
        step(1'b1);
        check("rst_mid_stall_cycles", bus.stall_cycles, 16'd0);
        rst = 1'b0;
        clear_inputs();
        step(1'b1);

        // Random traffic on a narrow register range so that addresses collide often.
        for (int i = 0; i < 400; i++) begin
            rst                 = ($urandom_range(0, 49) == 0);
            bus.forward_en      = ($urandom_range(0, 7) != 0) ? bus.forward_en : ~bus.forward_en;
            bus.regS_addr       = 5'($urandom_range(0, 3));
            bus.regT_addr       = 5'($urandom_range(0, 3));
            bus.use_regS        = 1'($urandom);
            bus.use_regT        = 1'($urandom);
            bus.reg_wr_en_ex    = 1'($urandom);
            bus.reg_wr_addr_ex  = 5'($urandom_range(0, 3));
            bus.mem_rd_ex       = 1'($urandom);
            bus.reg_wr_en_mem   = 1'($urandom);
            bus.reg_wr_addr_mem = 5'($urandom_range(0, 3));
            bus.branch_taken_ex = ($urandom_range(0, 7) == 0);
            step(1'b1);
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
